// File: rtl/axi_store_responder_pkg.sv
// Shared types, AXI constants and beat address helpers for the store responder
// and the store unit's address math.
package axi_store_responder_pkg;

    typedef logic [7:0] len_t;
    typedef logic [2:0] size_t;
    typedef logic [1:0] burst_t;
    typedef logic [1:0] resp_t;

    localparam burst_t BURST_FIXED = 2'b00;
    localparam burst_t BURST_INCR  = 2'b01;
    localparam burst_t BURST_WRAP  = 2'b10;
    localparam burst_t BURST_RSVD  = 2'b11;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [4:0]  id;
        logic [63:0] addr;
        len_t        len;
        size_t       size;
        burst_t      burst;
    } aw_chan_t;

    typedef struct packed {
        logic [127:0] data;
        logic [15:0]  strb;
        logic         last;
    } w_chan_t;

    typedef struct packed {
        logic [4:0] id;
        resp_t      resp;
    } b_chan_t;

    // Byte address of beat n; INCR beats after the first are size-aligned.
    function automatic logic [63:0] beat_addr(input logic [63:0] addr, input size_t size,
                                              input len_t n, input burst_t burst);
        logic [63:0] aligned;
        aligned = (addr >> size) << size;
        if (burst == BURST_FIXED || n == '0) return addr;
        return aligned + (64'(n) << size);
    endfunction

    function automatic logic [63:0] beat_word_addr(input logic [63:0] addr, input size_t size,
                                                   input len_t n, input burst_t burst,
                                                   input int unsigned off_bits);
        return beat_addr(addr, size, n, burst) >> off_bits;
    endfunction

endpackage

// File: rtl/axi_store_responder_fifo.sv
// Registered FIFO holding queued AW requests; a push is honoured on a full
// queue when a pop happens in the same cycle.
module axi_store_responder_fifo
    import axi_store_responder_pkg::*;
#(
    parameter int unsigned Depth = 4,
    parameter type T = aw_chan_t
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_data,
    output logic o_empty,
    output logic o_full
);
    localparam int unsigned PtrW = $clog2(Depth);

    logic [PtrW-1:0] r_rd, r_wr;
    logic [PtrW:0]   r_cnt;
    T                r_mem [Depth];
    logic            w_do_push, w_do_pop;

    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == (PtrW+1)'(Depth));
    assign o_data    = r_mem[r_rd];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) r_wr <= (r_wr == PtrW'(Depth - 1)) ? '0 : r_wr + 1'b1;
            if (w_do_pop)  r_rd <= (r_rd == PtrW'(Depth - 1)) ? '0 : r_rd + 1'b1;
            if (w_do_push && !w_do_pop)      r_cnt <= r_cnt + 1'b1;
            else if (w_do_pop && !w_do_push) r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/axi_store_responder.sv
// AXI write-side responder: queues AW bursts, writes strobed W beats into a
// word-addressed SRAM port and returns one B response per burst.
module axi_store_responder
    import axi_store_responder_pkg::*;
#(
    parameter int unsigned AxiDataWidth = 128,
    parameter int unsigned AxiAddrWidth = 64,
    parameter int unsigned AxiIdWidth   = 5,
    parameter int unsigned MemNumWords  = 1024,
    parameter int unsigned AwQueueDepth = 4,
    parameter type axi_aw_t = aw_chan_t,
    parameter type axi_w_t  = w_chan_t,
    parameter type axi_b_t  = b_chan_t,
    localparam int unsigned AddrBits = $clog2(MemNumWords)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  axi_aw_t                   axi_aw_i,
    input  logic                      axi_aw_valid_i,
    output logic                      axi_aw_ready_o,
    input  axi_w_t                    axi_w_i,
    input  logic                      axi_w_valid_i,
    output logic                      axi_w_ready_o,
    output axi_b_t                    axi_b_o,
    output logic                      axi_b_valid_o,
    input  logic                      axi_b_ready_i,
    output logic                      mem_req_o,
    output logic [AddrBits-1:0]       mem_addr_o,
    output logic [AxiDataWidth-1:0]   mem_wdata_o,
    output logic [AxiDataWidth/8-1:0] mem_be_o,
    input  logic                      mem_gnt_i,
    output logic                      busy_o
);
    localparam int unsigned NumBytes = AxiDataWidth / 8;
    localparam int unsigned OffBits  = $clog2(NumBytes);

    typedef enum logic {IDLE, DATA} state_e;

    state_e                  r_state, w_state_d;
    axi_aw_t                 w_head, r_aw;
    logic                    w_empty, w_full, w_push, w_pop;
    len_t                    r_cnt;
    logic                    r_supp;
    resp_t                   r_resp, w_pop_resp, w_final_resp;
    logic                    r_b_valid;
    logic [AxiIdWidth-1:0]   r_b_id;
    resp_t                   r_b_resp;
    logic [AxiAddrWidth-1:0] w_head_addr, w_cur_addr;
    logic [OffBits-1:0]      w_lower, w_upper, w_mask;
    logic                    w_last_beat, w_b_free, w_mismatch, w_w_hs;
    logic                    w_w_ready, w_mem_req, w_b_load;

    assign w_push         = axi_aw_valid_i && !w_full;
    assign axi_aw_ready_o = !w_full;

    axi_store_responder_fifo #(
        .Depth (AwQueueDepth),
        .T     (axi_aw_t)
    ) i_aw_queue (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_push),
        .i_data  (axi_aw_i),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign w_head_addr  = w_head.addr;
    assign w_cur_addr   = r_aw.addr;
    assign w_last_beat  = (r_cnt == r_aw.len);
    assign w_b_free     = !r_b_valid || axi_b_ready_i;
    assign w_mismatch   = (axi_w_i.last != w_last_beat);
    assign w_w_hs       = axi_w_valid_i && w_w_ready;
    assign w_final_resp = (w_mismatch && r_resp != RESP_DECERR) ? RESP_SLVERR : r_resp;

    // Beat window: [beat offset, size-aligned offset + 2^size - 1] == offset | size mask.
    assign w_lower = OffBits'(beat_addr(64'(w_cur_addr), r_aw.size, r_cnt, r_aw.burst));
    assign w_mask  = OffBits'((8'd1 << r_aw.size) - 8'd1);
    assign w_upper = w_lower | w_mask;

    always_comb begin
        w_pop_resp = RESP_OKAY;
        if (w_head.burst == BURST_WRAP || w_head.burst == BURST_RSVD || 32'(w_head.size) > OffBits)
            w_pop_resp = RESP_SLVERR;
        if (beat_word_addr(64'(w_head_addr), w_head.size, '0, w_head.burst, OffBits) >= 64'(MemNumWords) ||
            beat_word_addr(64'(w_head_addr), w_head.size, w_head.len, w_head.burst, OffBits) >= 64'(MemNumWords))
            w_pop_resp = RESP_DECERR;
    end

    always_comb begin
        w_state_d = r_state;
        w_pop     = 1'b0;
        w_w_ready = 1'b0;
        w_mem_req = 1'b0;
        w_b_load  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_state_d = DATA;
                end
            end
            DATA: begin
                w_w_ready = (!w_last_beat || w_b_free) && (r_supp || mem_gnt_i);
                w_mem_req = axi_w_valid_i && !r_supp && (!w_last_beat || w_b_free);
                // Last beat pops the next AW directly so bursts run back-to-back.
                if (w_w_hs && w_last_beat) begin
                    w_b_load = 1'b1;
                    if (!w_empty) w_pop = 1'b1;
                    else          w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_aw   <= '0;
            r_cnt  <= '0;
            r_supp <= 1'b0;
            r_resp <= RESP_OKAY;
        end else if (w_pop) begin
            r_aw   <= w_head;
            r_cnt  <= '0;
            r_supp <= (w_pop_resp != RESP_OKAY);
            r_resp <= w_pop_resp;
        end else if (w_w_hs && !w_last_beat) begin
            r_cnt  <= r_cnt + len_t'(1);
            r_resp <= w_final_resp;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_b_valid <= 1'b0;
            r_b_id    <= '0;
            r_b_resp  <= RESP_OKAY;
        end else if (w_b_load) begin
            r_b_valid <= 1'b1;
            r_b_id    <= r_aw.id;
            r_b_resp  <= w_final_resp;
        end else if (axi_b_ready_i) begin
            r_b_valid <= 1'b0;
        end
    end

    always_comb begin
        axi_b_o      = '0;
        axi_b_o.id   = r_b_id;
        axi_b_o.resp = r_b_resp;
    end

    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (r_state == DATA) begin
            mem_addr_o  = AddrBits'(beat_word_addr(64'(w_cur_addr), r_aw.size, r_cnt, r_aw.burst, OffBits));
            mem_wdata_o = axi_w_i.data;
            for (int unsigned i = 0; i < NumBytes; i++)
                mem_be_o[i] = axi_w_i.strb[i] && (OffBits'(i) >= w_lower) && (OffBits'(i) <= w_upper);
        end
    end

    assign axi_w_ready_o = w_w_ready;
    assign mem_req_o     = w_mem_req;
    assign axi_b_valid_o = r_b_valid;
    assign busy_o        = !w_empty || (r_state == DATA) || r_b_valid;

endmodule

// File: doc/axi_store_responder.md
Name: axi_store_responder

Overview:
- AXI write-side responder: the memory end of the AW/W/B traffic produced by the vector store path.
- Accepts AW bursts into a small queue and consumes W beats per burst, applying beat-window byte masking.
- Writes strobed data into a word-addressed SRAM port and returns exactly one B response per burst.
- Used as the L2/scratchpad write front-end in system simulation and in the FPGA bring-up top.

Parameters:
AxiDataWidth, 128, W data width in bits; power of two, at least 64.
AxiAddrWidth, 64, AXI address width.
AxiIdWidth, 5, AXI ID width.
MemNumWords, 1024, SRAM depth in AxiDataWidth-bit words; the memory window starts at address 0.
AwQueueDepth, 4, number of queued AW requests; at least 2.
axi_aw_t / axi_w_t / axi_b_t, logic, AXI channel structs from the shared typedef macros.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous, active-low reset
axi_aw_i  in  axi_aw_t  AW request (id, addr, len, size, burst)
axi_aw_valid_i  in  1  AW valid
axi_aw_ready_o  out  1  AW ready = AW queue not full
axi_w_i  in  axi_w_t  W beat (data, strb, last)
axi_w_valid_i  in  1  W valid
axi_w_ready_o  out  1  W ready
axi_b_o  out  axi_b_t  B response (id, resp)
axi_b_valid_o  out  1  B valid
axi_b_ready_i  in  1  B ready
mem_req_o  out  1  SRAM write request
mem_addr_o  out  $clog2(MemNumWords)  SRAM word index
mem_wdata_o  out  AxiDataWidth  SRAM write data
mem_be_o  out  AxiDataWidth/8  SRAM byte enables
mem_gnt_i  in  1  SRAM grant; the write commits in the granting cycle
busy_o  out  1  AW queue non-empty, or FSM in DATA, or B valid

Behaviour:
- Reset:
  - AW queue empty; FSM in IDLE; beat counter 0; error flag clear; B register empty.
  - All outputs 0, except axi_aw_ready_o = 1.
- AW queue:
  - Registered FIFO of depth AwQueueDepth.
  - A push and a pop in the same cycle are both allowed when the queue is full.
- FSM IDLE:
  - If the queue is non-empty, pop the head into the burst register and go to DATA next cycle.
  - A W beat is therefore accepted no earlier than 2 cycles after its AW handshake.
- Burst checks at pop time:
  - Error code is SLVERR (2'b10) if burst is WRAP or reserved, or if 2^size > AxiDataWidth/8.
  - Error code is DECERR (2'b11) if any beat's word index is at or beyond MemNumWords. Evaluate this on the first and last beat addresses.
  - Any erroneous burst suppresses all SRAM writes but still consumes len+1 beats.
- FSM DATA, per beat n (0..len):
  - Beat address: INCR gives addr for n=0, else (addr aligned to 2^size) + n*2^size. FIXED gives addr.
  - Word index = beat address >> log2(AxiDataWidth/8).
  - Byte window [lower, upper] is the standard AXI beat window for INCR/FIXED.
  - mem_be_o = strb masked to that window.
  - mem_wdata_o = W data, passed through unmodified.
- W handshake:
  - Let last_beat = (n == len), taken from the counter, not from W last.
  - Let b_free = !axi_b_valid_o || axi_b_ready_i.
  - mem_req_o = DATA && w_valid && !err && (!last_beat || b_free).
  - axi_w_ready_o = DATA && (!last_beat || b_free) && (err || mem_gnt_i).
  - An all-zero mem_be_o still issues the request.
- W last mismatch:
  - W last not equal to last_beat sets SLVERR for the burst; remaining beats of the burst are still written.
  - Termination is always by counter.
  - DECERR takes priority over SLVERR.
- On the last-beat handshake:
  - Load the B register with {id, resp} (OKAY = 2'b00 if no error).
  - axi_b_valid_o rises the next cycle.
  - Go to IDLE, or directly pop the next AW if the queue is non-empty (zero-bubble back-to-back bursts).
- B register:
  - Single entry; holds stable while axi_b_valid_o && !axi_b_ready_i.
  - Load and drain may happen in the same cycle.
- Counters: beat counter is axi_pkg::len_t and resets to 0 at every AW pop; no wrap beyond len.
- Reset mid-burst: all state is dropped immediately; a partial burst gets no B.

Decomposition:
- Reuse common_cells fifo_v3 for the AW queue; no new sub-module.
- Add to ara_pkg:
  - AXI resp constants (RESP_OKAY, RESP_SLVERR, RESP_DECERR), or reuse axi_pkg's.
  - A beat_word_addr helper function, shared with the store unit's address math.
- FSM state enum {IDLE, DATA} stays local.

Test Plan:
- Single beat (AxiDataWidth=128): AW{id=3, addr=0x40, len=0, size=4, INCR}, W strb=16'hFFFF -> mem_addr_o=4 with be=FFFF; B{id=3, OKAY} one cycle after the W handshake.
- Unaligned INCR: AW{addr=0x104, len=2, size=4}, all strb=1 -> beat0 word 0x10 be=FFF0; beat1 word 0x11 be=FFFF; beat2 word 0x12 be=FFFF; one B.
- SRAM backpressure: mem_gnt_i low for 3 cycles on beat 1 of a len=3 burst -> axi_w_ready_o low for those cycles; data and address held; all 4 writes land in order.
- B stall: axi_b_ready_i low while the next burst reaches its last beat -> that last beat is not accepted until B drains; queued AWs are still accepted up to 4.
- Errors:
  - AW addr=MemNumWords*16 -> 2 beats consumed, no mem_req_o, B=DECERR.
  - WRAP burst -> SLVERR.
  - W last asserted on beat 0 of len=1 -> both beats written, B=SLVERR.
- Back-to-back: 4 AWs queued, len=0 each -> W accepted on 4 consecutive cycles, 4 B in order with matching ids; assert reset mid-stream -> busy_o=0 the cycle after reset.
